// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use bubbles, redirect flushes, memory-busy freeze
// and saturating performance counters for the five-stage CPU.
module hazard_controller #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_RegWr,
   input  logic             ex_is_load,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] memwait_cnt
);

   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] LOAD_STALL = 2'd1;
   localparam logic [1:0] MEM_WAIT   = 2'd2;

   localparam logic [2:0]       BCNT_INIT = 3'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [1:0]       state_q, state_d;
   logic             ret_stall_q, ret_stall_d;
   logic [2:0]       bcnt_q, bcnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
   logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;
   logic             load_use;
   logic             in_stall;
   logic             redirect_taken;

   always_comb begin
      load_use = ex_is_load & ex_RegWr & (ex_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
      // MEM_WAIT resumes as whichever state it froze, so a stall continues seamlessly
      in_stall = (state_q == LOAD_STALL) | ((state_q == MEM_WAIT) & ret_stall_q);

      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      ifid_flush     = 1'b0;
      idex_write     = 1'b1;
      idex_flush     = 1'b0;
      exmem_write    = 1'b1;
      memwb_bubble   = 1'b0;
      state_d        = RUN;
      ret_stall_d    = ret_stall_q;
      bcnt_d         = bcnt_q;
      redirect_taken = 1'b0;

      if (!Reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_write   = 1'b0;
         idex_flush   = 1'b1;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
         ret_stall_d  = 1'b0;
         bcnt_d       = 3'd0;
      end else if (mem_busy) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
         state_d      = MEM_WAIT;
         ret_stall_d  = in_stall;
      end else if (in_stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
         ret_stall_d = 1'b0;
         if (bcnt_q <= 3'd1) begin
            state_d = RUN;
            bcnt_d  = 3'd0;
         end else begin
            state_d = LOAD_STALL;
            bcnt_d  = bcnt_q - 3'd1;
         end
      end else if (ex_redirect) begin
         ifid_flush     = 1'b1;
         idex_flush     = 1'b1;
         ret_stall_d    = 1'b0;
         redirect_taken = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
         ret_stall_d = 1'b0;
         if (LOAD_LAT > 1) begin
            state_d = LOAD_STALL;
            bcnt_d  = BCNT_INIT;
         end
      end else begin
         ret_stall_d = 1'b0;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      redirect_cnt_d = redirect_cnt_q;
      memwait_cnt_d  = memwait_cnt_q;
      if (!pc_write && stall_cycles_q != CNT_MAX)
         stall_cycles_d = stall_cycles_q + 1'b1;
      if (redirect_taken && redirect_cnt_q != CNT_MAX)
         redirect_cnt_d = redirect_cnt_q + 1'b1;
      if (mem_busy && state_q != MEM_WAIT && memwait_cnt_q != CNT_MAX)
         memwait_cnt_d = memwait_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q        <= RUN;
         ret_stall_q    <= 1'b0;
         bcnt_q         <= 3'd0;
         stall_cycles_q <= '0;
         redirect_cnt_q <= '0;
         memwait_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         ret_stall_q    <= ret_stall_d;
         bcnt_q         <= bcnt_d;
         stall_cycles_q <= stall_cycles_d;
         redirect_cnt_q <= redirect_cnt_d;
         memwait_cnt_q  <= memwait_cnt_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign redirect_cnt = redirect_cnt_q;
   assign memwait_cnt  = memwait_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: three instances (LOAD_LAT=1/3, CNT_W=32/4) share stimulus
// and are compared each cycle against a bubble-count reference model.
module tb_hazard_controller;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_RegWr, ex_is_load, ex_redirect, mem_busy;

   logic [2:0]  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble;
   logic [31:0] stall_a, redir_a, mw_a, stall_b, redir_b, mw_b;
   logic [3:0]  stall_c, redir_c, mw_c;
   logic [31:0] obs_stall [3];
   logic [31:0] obs_redir [3];
   logic [31:0] obs_mw [3];

   int n_asserts = 0;
   int n_fails   = 0;

   // Reference model: outstanding bubbles per instance plus plain counters
   int      lat [3]   = '{1, 3, 1};
   longint  maxv [3]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   int      pend [3];
   longint  m_stall [3];
   longint  m_redir [3];
   longint  m_mw [3];
   bit      was_busy;

   always #5 CLK = ~CLK;

   hazard_controller #(.LOAD_LAT(1), .CNT_W(32)) dut_a (
      .CLK(CLK), .Reset(Reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_RegWr(ex_RegWr), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_busy(mem_busy), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
      .ifid_flush(ifid_flush[0]), .idex_write(idex_write[0]), .idex_flush(idex_flush[0]),
      .exmem_write(exmem_write[0]), .memwb_bubble(memwb_bubble[0]),
      .stall_cycles(stall_a), .redirect_cnt(redir_a), .memwait_cnt(mw_a));

   hazard_controller #(.LOAD_LAT(3), .CNT_W(32)) dut_b (
      .CLK(CLK), .Reset(Reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_RegWr(ex_RegWr), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_busy(mem_busy), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
      .ifid_flush(ifid_flush[1]), .idex_write(idex_write[1]), .idex_flush(idex_flush[1]),
      .exmem_write(exmem_write[1]), .memwb_bubble(memwb_bubble[1]),
      .stall_cycles(stall_b), .redirect_cnt(redir_b), .memwait_cnt(mw_b));

   hazard_controller #(.LOAD_LAT(1), .CNT_W(4)) dut_c (
      .CLK(CLK), .Reset(Reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_RegWr(ex_RegWr), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_busy(mem_busy), .pc_write(pc_write[2]), .ifid_write(ifid_write[2]),
      .ifid_flush(ifid_flush[2]), .idex_write(idex_write[2]), .idex_flush(idex_flush[2]),
      .exmem_write(exmem_write[2]), .memwb_bubble(memwb_bubble[2]),
      .stall_cycles(stall_c), .redirect_cnt(redir_c), .memwait_cnt(mw_c));

   assign obs_stall[0] = stall_a;
   assign obs_stall[1] = stall_b;
   assign obs_stall[2] = {28'd0, stall_c};
   assign obs_redir[0] = redir_a;
   assign obs_redir[1] = redir_b;
   assign obs_redir[2] = {28'd0, redir_c};
   assign obs_mw[0]    = mw_a;
   assign obs_mw[1]    = mw_b;
   assign obs_mw[2]    = {28'd0, mw_c};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, check 1 ns later, then advance the model
   task automatic applyStimulus(input logic rst_n, input logic busy, input logic redir,
                                input logic ld, input logic rw, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2);
      logic lu;
      logic e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_wbb;
      logic stall_inc, redir_inc;
      @(negedge CLK);
      Reset = rst_n; mem_busy = busy; ex_redirect = redir; ex_is_load = ld;
      ex_RegWr = rw; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      #1;
      lu = ld && rw && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      for (int i = 0; i < 3; i++) begin
         stall_inc = 1'b0;
         redir_inc = 1'b0;
         {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_wbb} = 7'b1101010;
         if (!rst_n) begin
            {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_wbb} = 7'b0010101;
            pend[i] = 0; m_stall[i] = 0; m_redir[i] = 0; m_mw[i] = 0;
         end else if (busy) begin
            {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_wbb} = 7'b0000001;
            stall_inc = 1'b1;
         end else if (pend[i] > 0) begin
            {e_pc, e_ifw, e_idf} = 3'b001;
            stall_inc = 1'b1;
            pend[i]--;
         end else if (redir) begin
            {e_iff, e_idf} = 2'b11;
            redir_inc = 1'b1;
         end else if (lu) begin
            {e_pc, e_ifw, e_idf} = 3'b001;
            stall_inc = 1'b1;
            pend[i] = lat[i] - 1;
         end
         checkOutput($sformatf("dut%0d.pc_write", i),     {31'd0, pc_write[i]},     {31'd0, e_pc});
         checkOutput($sformatf("dut%0d.ifid_write", i),   {31'd0, ifid_write[i]},   {31'd0, e_ifw});
         checkOutput($sformatf("dut%0d.ifid_flush", i),   {31'd0, ifid_flush[i]},   {31'd0, e_iff});
         checkOutput($sformatf("dut%0d.idex_write", i),   {31'd0, idex_write[i]},   {31'd0, e_idw});
         checkOutput($sformatf("dut%0d.idex_flush", i),   {31'd0, idex_flush[i]},   {31'd0, e_idf});
         checkOutput($sformatf("dut%0d.exmem_write", i),  {31'd0, exmem_write[i]},  {31'd0, e_exw});
         checkOutput($sformatf("dut%0d.memwb_bubble", i), {31'd0, memwb_bubble[i]}, {31'd0, e_wbb});
         checkOutput($sformatf("dut%0d.stall_cycles", i), obs_stall[i], m_stall[i][31:0]);
         checkOutput($sformatf("dut%0d.redirect_cnt", i), obs_redir[i], m_redir[i][31:0]);
         checkOutput($sformatf("dut%0d.memwait_cnt", i),  obs_mw[i],    m_mw[i][31:0]);
         if (rst_n) begin
            if (stall_inc && m_stall[i] < maxv[i]) m_stall[i]++;
            if (redir_inc && m_redir[i] < maxv[i]) m_redir[i]++;
            if (busy && !was_busy && m_mw[i] < maxv[i]) m_mw[i]++;
         end
      end
      was_busy = rst_n && busy;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic hazard(input logic busy, input logic redir, input logic [4:0] rd);
      applyStimulus(1, busy, redir, 1, 1, rd, 5'd1, rd, 0, 1);
   endtask

   initial begin
      was_busy = 0;
      for (int i = 0; i < 3; i++) begin
         pend[i] = 0; m_stall[i] = 0; m_redir[i] = 0; m_mw[i] = 0;
      end
      Reset = 0; mem_busy = 0; ex_redirect = 0; ex_is_load = 0; ex_RegWr = 0;
      ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;

      // Reset held for three cycles, then a quiet cycle
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Load-use on rs2 = x5, then the same with rd = x0
      hazard(0, 0, 5'd5);
      idle(3);
      hazard(0, 0, 5'd0);
      idle(1);
      applyStimulus(1, 0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 1, 1);
      idle(1);

      // Hazard with a two-cycle memory freeze in the middle of the stall
      hazard(0, 0, 5'd7);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Redirect wins over load-use
      hazard(0, 1, 5'd9);
      idle(1);

      // Redirect blocked by mem_busy for four cycles, honoured on the fifth
      for (int k = 0; k < 4; k++) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Reset in the middle of a LOAD_LAT=3 stall
      hazard(0, 0, 5'd3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Twenty back-to-back hazards saturate the 4-bit counter
      for (int k = 0; k < 20; k++) hazard(0, 0, 5'd4);
      idle(3);

      // Randomized traffic with a small register space so hazards are frequent
      for (int k = 0; k < 600; k++) begin
         applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the five-stage CPU.
- Detects load-use hazards, which forwarding cannot resolve, and inserts bubbles.
- Flushes wrong-path instructions when a branch or jump is resolved in EXE.
- Freezes the whole pipeline while data memory is busy.
- Drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating performance counters.

Parameters:
- LOAD_LAT, 1: bubbles inserted per load-use hazard (1..7).
- CNT_W, 32: width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of instruction in EXE.
- ex_RegWr  in  1  EXE instruction writes the register file.
- ex_is_load  in  1  EXE instruction is a load (RegDst selects DataOut).
- ex_redirect  in  1  taken branch or jump resolved in EXE this cycle.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_write  out  1  ID/EX enable.
- idex_flush  out  1  ID/EX loads bubble (RegWr=0, Mwk=0).
- exmem_write  out  1  EX/MEM enable.
- memwb_bubble  out  1  MEM/WB loads bubble.
- stall_cycles  out  CNT_W  cycles with pc_write=0.
- redirect_cnt  out  CNT_W  flush events.
- memwait_cnt  out  CNT_W  entries into MEM_WAIT.

Behaviour:
- State register: RUN, LOAD_STALL, MEM_WAIT. Also a 3-bit bubble counter bcnt.
- Outputs are combinational from the state and the current inputs. State, bcnt and the counters are registered.
- While Reset=0:
  - All write enables = 0; ifid_flush = idex_flush = memwb_bubble = 1.
  - State = RUN; bcnt = 0; all counters = 0.
  - Reset asserted mid-stall aborts the stall immediately.
- Default (RUN, no event): all write enables = 1; all flush/bubble outputs = 0.
- load_use = ex_is_load & ex_RegWr & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Priority (highest first): mem_busy > ex_redirect > load_use.
- mem_busy=1, any state:
  - Freeze: pc_write = ifid_write = idex_write = exmem_write = 0; memwb_bubble = 1; no flushes.
  - Next state MEM_WAIT. bcnt holds.
  - If mem_busy was asserted from LOAD_STALL, the return state remembers LOAD_STALL.
- MEM_WAIT with mem_busy=0: behaves exactly as the remembered state (RUN or LOAD_STALL) this same cycle, with no dead cycle.
- ex_redirect=1 in RUN (mem_busy=0):
  - pc_write = 1 (loads target); ifid_write = 1.
  - ifid_flush = 1; idex_flush = 1.
  - load_use is ignored. Stay in RUN.
- load_use=1 in RUN (no higher event):
  - pc_write = ifid_write = 0; idex_flush = 1.
  - If LOAD_LAT>1: next state LOAD_STALL with bcnt = LOAD_LAT-1. Otherwise stay in RUN.
- LOAD_STALL:
  - Same outputs as the load_use cycle.
  - bcnt decrements each non-frozen cycle; go to RUN when bcnt reaches 1.
  - ex_redirect and load_use are ignored, because EXE holds a bubble.
- Counters: saturate at all-ones and never wrap.
  - stall_cycles +1 in any cycle with pc_write=0.
  - redirect_cnt +1 per cycle where redirect is honoured.
  - memwait_cnt +1 on each transition into MEM_WAIT from a non-MEM_WAIT state.
- rd=x0 never causes a stall. A load in EXE with ex_RegWr=0 never stalls.

Test Plan:
- Reset low for 3 cycles, then release with no events -> during reset all enables 0 and flushes 1. First cycle after release: all enables 1, flushes 0, counters 0.
- ex_is_load=1, ex_RegWr=1, ex_rd=5, id_rs2=5, id_use_rs2=1, LOAD_LAT=1 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1.
  - Same stimulus with ex_rd=0 -> no stall.
- LOAD_LAT=3, same hazard -> 3 consecutive stall cycles, then RUN. mem_busy=1 for 2 cycles in the middle -> 5 total stall cycles, memwait_cnt=1.
- ex_redirect=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_write=1 for 1 cycle; redirect_cnt=1; stall_cycles unchanged.
- mem_busy=1 together with ex_redirect=1 for 4 cycles, then ex_redirect held with mem_busy=0 -> 4 frozen cycles with memwb_bubble=1, then redirect honoured on cycle 5.
- Force stall_cycles to near saturation with CNT_W=4, via 20 load-use stalls -> counter holds at 15.
